// File: rtl/vjtag_gpio_bank_if.sv
// vjtag_gpio_bank_if
//   Host-side bus bundle between vjtag_host and the GPIO bank.
//   Ports carried:
//     address  host byte address (AW bits)
//     wvalid   write request          wdata   write data (DW bits)
//     wready   write accept (slave)
//     rvalid   read request           rready  read accept (slave)
//     rrvalid  read response valid    rdata   read response data (DW bits)
//   Modports: master = vjtag_host side, slave = GPIO bank side.
interface vjtag_gpio_bank_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] address;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          wready;
    logic          rvalid;
    logic          rready;
    logic          rrvalid;
    logic [DW-1:0] rdata;

    modport master (
        output address, wvalid, wdata, rvalid,
        input  wready, rready, rrvalid, rdata
    );

    modport slave (
        input  address, wvalid, wdata, rvalid,
        output wready, rready, rrvalid, rdata
    );
endinterface

// File: rtl/vjtag_gpio_bank.sv
// vjtag_gpio_bank
//   Multi-channel GPIO slave on the vjtag_host bus. Each channel has an
//   output register, a synchronised input, sticky change-detect bits
//   (write-1-to-clear) and a toggle port. irq is the registered OR of all
//   change-detect bits.
//   Ports:
//     clk         system clock
//     rst         synchronous reset, active-high (overrides everything)
//     soft_rst_n  host soft reset, active-low: clears OUT, EDGE and irq only
//     bus         vjtag_gpio_bank_if slave modport (always-ready host bus)
//     gpio_in     asynchronous pin inputs, channel c = [c*DW +: DW]
//     gpio_out    registered pin outputs
//     irq         pending-change interrupt, registered
//   Register map per channel c at BASE + 16*c:
//     +0x0 OUT (RW), +0x4 IN (RO), +0x8 EDGE (RW1C), +0xC TGL (WO, reads 0)
module vjtag_gpio_bank #(
    parameter int            AW      = 16,
    parameter int            DW      = 16,
    parameter int            NCH     = 2,
    parameter int            BASE    = 0,
    parameter int            SYNC    = 2,
    parameter logic [DW-1:0] OUT_RST = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_n,
    vjtag_gpio_bank_if.slave      bus,
    input  logic [NCH*DW-1:0]     gpio_in,
    output logic [NCH*DW-1:0]     gpio_out,
    output logic                  irq
);

    localparam int                CW       = AW - 4;
    localparam int                WCW      = $clog2(SYNC + 2);
    localparam logic [WCW-1:0]    WARM_MAX = WCW'(SYNC + 1);
    localparam logic [1:0]        REG_OUT  = 2'd0;
    localparam logic [1:0]        REG_IN   = 2'd1;
    localparam logic [1:0]        REG_EDGE = 2'd2;
    localparam logic [1:0]        REG_TGL  = 2'd3;
    localparam logic [NCH*DW-1:0] ZERO_BUS = {(NCH*DW){1'b0}};
    localparam logic [DW-1:0]     ZERO_W   = {DW{1'b0}};

    logic [NCH*DW-1:0] sync_r [SYNC];
    logic [NCH*DW-1:0] prev_r;
    logic [NCH*DW-1:0] out_r;
    logic [NCH*DW-1:0] edge_r;
    logic [NCH*DW-1:0] in_s;
    logic [NCH*DW-1:0] set_s;
    logic [NCH*DW-1:0] w1c_s;
    logic [NCH*DW-1:0] out_nxt_s;
    logic [NCH*DW-1:0] edge_nxt_s;
    logic [WCW-1:0]    warm_r;
    logic              warm_done_s;
    logic [AW-1:0]     off_s;
    logic [CW-1:0]     ch_s;
    logic [1:0]        reg_s;
    logic              mapped_s;
    logic              wr_en_s;
    logic [DW-1:0]     rd_s;
    logic              rrvalid_r;
    logic [DW-1:0]     rdata_r;
    logic              irq_r;

    assign in_s        = sync_r[SYNC-1];
    assign warm_done_s = (warm_r == WARM_MAX);
    // Change detection stays masked until the synchroniser has flushed the
    // zeros loaded at reset, so pins already high at reset raise no EDGE.
    assign set_s       = warm_done_s ? (in_s ^ prev_r) : ZERO_BUS;

    // Address decode relative to BASE; below BASE the subtraction wraps and
    // the explicit compare rejects it.
    assign off_s    = bus.address - AW'(BASE);
    assign ch_s     = off_s[AW-1:4];
    assign reg_s    = off_s[3:2];
    assign mapped_s = (bus.address >= AW'(BASE)) && (off_s[1:0] == 2'b00) &&
                      (ch_s < CW'(NCH));
    assign wr_en_s  = bus.wvalid && mapped_s && soft_rst_n;

    // Next-state for OUT/TGL writes and EDGE write-1-to-clear (set wins).
    always_comb begin
        out_nxt_s = out_r;
        w1c_s     = ZERO_BUS;
        for (int c = 0; c < NCH; c++) begin
            if (wr_en_s && (ch_s == CW'(c))) begin
                case (reg_s)
                    REG_OUT:  out_nxt_s[c*DW +: DW] = bus.wdata;
                    REG_TGL:  out_nxt_s[c*DW +: DW] = out_r[c*DW +: DW] ^ bus.wdata;
                    REG_EDGE: w1c_s[c*DW +: DW]     = bus.wdata;
                    default:  out_nxt_s[c*DW +: DW] = out_r[c*DW +: DW];
                endcase
            end else begin
                out_nxt_s[c*DW +: DW] = out_r[c*DW +: DW];
            end
        end
        edge_nxt_s = (edge_r & ~w1c_s) | set_s;
    end

    // Read data mux; TGL and unmapped addresses return zero.
    always_comb begin
        rd_s = ZERO_W;
        for (int c = 0; c < NCH; c++) begin
            if (mapped_s && (ch_s == CW'(c))) begin
                case (reg_s)
                    REG_OUT:  rd_s = out_r[c*DW +: DW];
                    REG_IN:   rd_s = in_s[c*DW +: DW];
                    REG_EDGE: rd_s = edge_r[c*DW +: DW];
                    default:  rd_s = ZERO_W;
                endcase
            end else begin
                rd_s = rd_s;
            end
        end
    end

    // Input synchroniser, previous-value register and warm-up counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) begin
                sync_r[i] <= ZERO_BUS;
            end
            prev_r <= ZERO_BUS;
            warm_r <= {WCW{1'b0}};
        end else begin
            sync_r[0] <= gpio_in;
            for (int i = 1; i < SYNC; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= in_s;
            if (!warm_done_s) begin
                warm_r <= warm_r + WCW'(1);
            end else begin
                warm_r <= warm_r;
            end
        end
    end

    // Output, sticky-edge and interrupt registers with hard and soft reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r  <= {NCH{OUT_RST}};
            edge_r <= ZERO_BUS;
            irq_r  <= 1'b0;
        end else if (!soft_rst_n) begin
            out_r  <= {NCH{OUT_RST}};
            edge_r <= ZERO_BUS;
            irq_r  <= 1'b0;
        end else begin
            out_r  <= out_nxt_s;
            edge_r <= edge_nxt_s;
            irq_r  <= |edge_r;
        end
    end

    // Read response: one-cycle rrvalid pulse, rdata held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrvalid_r <= 1'b0;
            rdata_r   <= ZERO_W;
        end else begin
            rrvalid_r <= bus.rvalid;
            if (bus.rvalid) begin
                rdata_r <= rd_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.wready  = 1'b1;
    assign bus.rready  = 1'b1;
    assign bus.rrvalid = rrvalid_r;
    assign bus.rdata   = rdata_r;
    assign gpio_out    = out_r;
    assign irq         = irq_r;

endmodule

// File: tb/tb_vjtag_gpio_bank.sv
// tb_vjtag_gpio_bank
//   Self-checking bench for vjtag_gpio_bank (NCH=2, DW=16, SYNC=2, BASE=0).
//   A vector table exercises single-cycle bus accesses; hand-written
//   sequences cover input synchronisation, EDGE/irq timing, set-vs-clear,
//   soft reset and hard reset.
module tb_vjtag_gpio_bank;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int NV  = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_rst_n;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    vjtag_gpio_bank_if #(.AW(AW), .DW(DW)) bus ();

    vjtag_gpio_bank #(
        .AW(AW), .DW(DW), .NCH(NCH), .BASE(0), .SYNC(2), .OUT_RST(16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst_n (soft_rst_n),
        .bus        (bus),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_rrvalid;
        logic [15:0] exp_rdata;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [15:0] d);
        bus.address = a;
        bus.wdata   = d;
        bus.wvalid  = 1'b1;
        tick();
        bus.wvalid  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        bus.address = a;
        bus.rvalid  = 1'b1;
        tick();
        bus.rvalid  = 1'b0;
        chk({name, "_rrvalid"}, 32'(bus.rrvalid), 32'd1);
        chk(name, 32'(bus.rdata), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        wr    addr      wdata     rrv   rdata     gpio_out
        vecs[0]  = '{1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'h0000, 32'h0000_A5A5};
        vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 32'h0000_A5A5};
        vecs[2]  = '{1'b1, 16'h0004, 16'hFFFF, 1'b0, 16'hA5A5, 32'h0000_A5A5};
        vecs[3]  = '{1'b1, 16'h0010, 16'h00FF, 1'b0, 16'hA5A5, 32'h00FF_A5A5};
        vecs[4]  = '{1'b1, 16'h001C, 16'h0F0F, 1'b0, 16'hA5A5, 32'h0FF0_A5A5};
        vecs[5]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0FF0, 32'h0FF0_A5A5};
        vecs[6]  = '{1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0000, 32'h0FF0_A5A5};
        vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 32'h0FF0_A5A5};
        vecs[8]  = '{1'b0, 16'h001C, 16'h0000, 1'b1, 16'h0000, 32'h0FF0_A5A5};
        vecs[9]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0FF0, 32'h0FF0_A5A5};
        vecs[10] = '{1'b0, 16'h0002, 16'h0000, 1'b1, 16'h0000, 32'h0FF0_A5A5};
        vecs[11] = '{1'b1, 16'h0022, 16'hFFFF, 1'b0, 16'h0000, 32'h0FF0_A5A5};
        vecs[12] = '{1'b1, 16'h0002, 16'hFFFF, 1'b0, 16'h0000, 32'h0FF0_A5A5};
        vecs[13] = '{1'b1, 16'h000C, 16'hFFFF, 1'b0, 16'h0000, 32'h0FF0_5A5A};
        vecs[14] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, 32'h0FF0_5A5A};
        vecs[15] = '{1'b1, 16'h0030, 16'h1111, 1'b0, 16'h5A5A, 32'h0FF0_5A5A};
        vecs[16] = '{1'b0, 16'h0004, 16'h0000, 1'b1, 16'h0000, 32'h0FF0_5A5A};
        vecs[17] = '{1'b0, 16'h0014, 16'h0000, 1'b1, 16'h0000, 32'h0FF0_5A5A};
        vecs[18] = '{1'b0, 16'h0008, 16'h0000, 1'b1, 16'h0000, 32'h0FF0_5A5A};

        rst         = 1'b1;
        soft_rst_n  = 1'b1;
        gpio_in     = 32'h0000_0000;
        bus.address = 16'h0000;
        bus.wdata   = 16'h0000;
        bus.wvalid  = 1'b0;
        bus.rvalid  = 1'b0;
        tick();
        tick();
        chk("rst_gpio_out", gpio_out, 32'h0000_0000);
        chk("rst_rrvalid", 32'(bus.rrvalid), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd1);
        chk("rst_rready", 32'(bus.rready), 32'd1);
        rst = 1'b0;
        repeat (5) tick();

        // Single-cycle bus accesses, back to back.
        for (int i = 0; i < NV; i++) begin
            bus.address = vecs[i].addr;
            bus.wdata   = vecs[i].wdata;
            bus.wvalid  = vecs[i].is_wr;
            bus.rvalid  = ~vecs[i].is_wr;
            tick();
            bus.wvalid  = 1'b0;
            bus.rvalid  = 1'b0;
            chk($sformatf("vec%0d_rrvalid", i), 32'(bus.rrvalid), 32'(vecs[i].exp_rrvalid));
            chk($sformatf("vec%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].exp_out);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'd0);
        end

        // Input change on ch1: IN after 2 clocks, EDGE one later, irq one after that.
        gpio_in = 32'h0003_0000;
        tick();
        chk("in_irq_e1", 32'(irq), 32'd0);
        rd_chk("in_ch1_e2", 16'h0014, 16'h0000);
        rd_chk("in_ch1_e3", 16'h0014, 16'h0003);
        chk("in_irq_e3", 32'(irq), 32'd0);
        rd_chk("edge_ch1_e4", 16'h0018, 16'h0003);
        chk("in_irq_e4", 32'(irq), 32'd1);
        rd_chk("edge_ch0", 16'h0008, 16'h0000);

        // W1C of bit0 in the same cycle a new bit-0 change sets it: set wins.
        gpio_in = 32'h0002_0000;
        tick();
        tick();
        do_wr(16'h0018, 16'h0001);
        rd_chk("edge_set_wins", 16'h0018, 16'h0003);
        do_wr(16'h0018, 16'h0001);
        rd_chk("edge_w1c", 16'h0018, 16'h0002);
        chk("irq_still_set", 32'(irq), 32'd1);
        do_wr(16'h0018, 16'h0002);
        rd_chk("edge_clear", 16'h0018, 16'h0000);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Soft reset clears OUT/EDGE/irq, drops a concurrent write, keeps IN.
        do_wr(16'h0000, 16'h1234);
        chk("soft_pre_out", gpio_out, 32'h0FF0_1234);
        gpio_in = 32'h0002_0020;
        repeat (4) tick();
        chk("soft_pre_irq", 32'(irq), 32'd1);
        soft_rst_n  = 1'b0;
        bus.address = 16'h0010;
        bus.wdata   = 16'hBEEF;
        bus.wvalid  = 1'b1;
        tick();
        soft_rst_n  = 1'b1;
        bus.wvalid  = 1'b0;
        chk("soft_out", gpio_out, 32'h0000_0000);
        chk("soft_irq", 32'(irq), 32'd0);
        rd_chk("soft_edge_ch0", 16'h0008, 16'h0000);
        rd_chk("soft_in_ch0", 16'h0004, 16'h0020);
        chk("soft_write_dropped", gpio_out, 32'h0000_0000);

        // Hard reset during a read: no response; pins high at reset give no EDGE.
        do_wr(16'h0010, 16'h00AA);
        chk("hrst_pre_out", gpio_out, 32'h00AA_0000);
        rd_chk("hrst_pre_rd", 16'h0004, 16'h0020);
        bus.address = 16'h0004;
        bus.rvalid  = 1'b1;
        rst         = 1'b1;
        tick();
        bus.rvalid  = 1'b0;
        chk("hrst_rrvalid", 32'(bus.rrvalid), 32'd0);
        chk("hrst_rdata", 32'(bus.rdata), 32'd0);
        chk("hrst_out", gpio_out, 32'h0000_0000);
        tick();
        rst = 1'b0;
        tick();
        chk("hrst_no_late_rrvalid", 32'(bus.rrvalid), 32'd0);
        repeat (6) tick();
        chk("warm_irq", 32'(irq), 32'd0);
        rd_chk("warm_edge_ch0", 16'h0008, 16'h0000);
        rd_chk("warm_edge_ch1", 16'h0018, 16'h0000);
        rd_chk("warm_in_ch0", 16'h0004, 16'h0020);
        rd_chk("warm_in_ch1", 16'h0014, 16'h0002);
        tick();
        chk("rrvalid_pulse_end", 32'(bus.rrvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
